sr04_trig_sequencer: RTL and testbench

//  Multi-channel HC-SR04 trigger sequencer; parametrised successor of the single-channel trigger generator.

---
 rtl/sr04_trig_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sr04_trig_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_trig_sequencer.sv
// ---------------------------------------------------------------------------
// sr04_trig_sequencer
//
// Multi-channel HC-SR04 trigger sequencer. Fires one trigger pulse of
// PULSE_TICKS microsecond ticks on a selected channel, then waits an echo /
// settle window of HOLDOFF_TICKS ticks before the next channel may fire.
// Channels are picked round-robin from the enabled set in i_ch_mask, either
// once per i_start request or continuously while i_auto is high.
//
// Optional feature (compile-time macro):
//   SR04_ECHO_EARLY_EN  adds the i_echo_done input; a high i_echo_done while
//                       in HOLD ends the holdoff window on that clock, exactly
//                       as if the holdoff count had expired.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   i_tick       1-clk strobe, one per microsecond
//   i_start      single-shot request, sampled only while idle
//   i_auto       level, continuous sequencing while high
//   i_ch_mask    per-channel enable mask
//   i_echo_done  (SR04_ECHO_EARLY_EN only) echo measurement finished
//   o_trig       per-channel trigger outputs, registered, at most one high
//   o_ch_sel     channel currently or most recently triggered
//   o_busy       high while a pulse or holdoff window is in progress
//   o_done       1-clk pulse when a channel's holdoff window ends
// ---------------------------------------------------------------------------
module sr04_trig_sequencer #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned PULSE_TICKS   = 10,
    parameter int unsigned HOLDOFF_TICKS = 60000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned CH_W          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_start,
    input  logic              i_auto,
    input  logic [NUM_CH-1:0] i_ch_mask,
`ifdef SR04_ECHO_EARLY_EN
    input  logic              i_echo_done,
`endif
    output logic [NUM_CH-1:0] o_trig,
    output logic [CH_W-1:0]   o_ch_sel,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_TICKS - 1);
    // Reset value of the round-robin pointer: the search starts just after
    // it, so the first fire picks the lowest enabled channel.
    localparam logic [CH_W-1:0]  LAST_RST   = CH_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [NUM_CH-1:0]   trig_q, trig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Round-robin selection
    logic                mask_any;
    logic                above_found;
    logic [CH_W-1:0]     above_ch;
    logic                low_found;
    logic [CH_W-1:0]     low_ch;
    logic [CH_W-1:0]     nxt_ch;
    logic [NUM_CH-1:0]   nxt_onehot;
    logic                hold_end;
    logic                echo_early;

    assign mask_any = |i_ch_mask;

    // The wrap-around search last+1, last+2, ... mod NUM_CH is split in two:
    // the lowest enabled channel above last_q wins; if there is none, the
    // search has wrapped and the lowest enabled channel overall wins. The
    // wrapped case includes last_q itself when it is the only one enabled.
    always_comb begin
        above_found = 1'b0;
        above_ch    = '0;
        low_found   = 1'b0;
        low_ch      = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (i_ch_mask[c] && !low_found) begin
                low_found = 1'b1;
                low_ch    = CH_W'(c);
            end
            if (i_ch_mask[c] && !above_found && (CH_W'(c) > last_q)) begin
                above_found = 1'b1;
                above_ch    = CH_W'(c);
            end
        end
        nxt_ch = above_found ? above_ch : low_ch;
    end

    always_comb begin
        nxt_onehot = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            nxt_onehot[c] = (nxt_ch == CH_W'(c));
        end
    end

`ifdef SR04_ECHO_EARLY_EN
    assign echo_early = i_echo_done;
`else
    assign echo_early = 1'b0;
`endif

    // Only meaningful in HOLD; the state decode below gates its use.
    assign hold_end = (i_tick && (cnt_q == HOLD_LAST)) || echo_early;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ch_sel_d = ch_sel_q;
        trig_d   = trig_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                trig_d = '0;
                busy_d = 1'b0;
                if ((i_start || i_auto) && mask_any) begin
                    state_d  = ST_PULSE;
                    cnt_d    = '0;
                    last_d   = nxt_ch;
                    ch_sel_d = nxt_ch;
                    trig_d   = nxt_onehot;
                    busy_d   = 1'b1;
                end
            end

            ST_PULSE: begin
                // The selected channel is latched; mask changes here only
                // influence the next selection.
                if (i_tick) begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        trig_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                trig_d = '0;
                if (hold_end) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // Continuous mode chains straight into the next pulse
                    // on the same edge as the done strobe.
                    if (i_auto && mask_any) begin
                        state_d  = ST_PULSE;
                        last_d   = nxt_ch;
                        ch_sel_d = nxt_ch;
                        trig_d   = nxt_onehot;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                trig_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= LAST_RST;
            ch_sel_q <= '0;
            trig_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ch_sel_q <= ch_sel_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_trig   = trig_q;
    assign o_ch_sel = ch_sel_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_sr04_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr04_trig_sequencer
//
// Scoreboard bench for sr04_trig_sequencer (NUM_CH=4, PULSE_TICKS=10,
// HOLDOFF_TICKS=20, i_tick every 4 clocks). Stimulus predicts each trigger
// event (channel, whether it chains off a done strobe, holdoff length in
// ticks) and queues it; a monitor pops an entry on every trigger rise and
// checks pulse and holdoff lengths by counting ticks it observes.
// Define SR04_ECHO_EARLY_EN to also exercise the early echo termination.
// ---------------------------------------------------------------------------
module tb_sr04_trig_sequencer;

    localparam int NUM_CH = 4;
    localparam int PULSE  = 10;
    localparam int HOLD   = 20;
    localparam int BUDGET = 2000;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_tick;
    logic                i_start;
    logic                i_auto;
    logic [NUM_CH-1:0]   i_ch_mask;
    logic                i_echo_done;
    logic [NUM_CH-1:0]   o_trig;
    logic [1:0]          o_ch_sel;
    logic                o_busy;
    logic                o_done;

    always #5 clk = ~clk;

    sr04_trig_sequencer #(
        .NUM_CH        (NUM_CH),
        .PULSE_TICKS   (PULSE),
        .HOLDOFF_TICKS (HOLD),
        .CNT_W         (16),
        .CH_W          (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_start     (i_start),
        .i_auto      (i_auto),
        .i_ch_mask   (i_ch_mask),
`ifdef SR04_ECHO_EARLY_EN
        .i_echo_done (i_echo_done),
`endif
        .o_trig      (o_trig),
        .o_ch_sel    (o_ch_sel),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        int ch;
        bit chained;
        int hold;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur;
    bit    cur_valid = 1'b0;
    int    phase = 0;          // 0 idle, 1 pulse, 2 holdoff (as observed)
    int    pulse_ticks = 0;
    int    hold_ticks = 0;
    int    rise_count = 0;
    int    done_count = 0;
    int    errors = 0;
    int    checks = 0;
    int    model_last = NUM_CH - 1;
    int    tick_div = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference round-robin: first enabled channel after 'last', wrapping.
    function automatic int next_ch(int last, logic [NUM_CH-1:0] mask);
        for (int off = 1; off <= NUM_CH; off++) begin
            int c = (last + off) % NUM_CH;
            if (((mask >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    // Tick strobe: one clock high in every four.
    initial begin
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div++;
            i_tick = ((tick_div % 4) == 0);
        end
    end

    // Monitor: samples #1 after each rising edge; the inputs seen then are
    // the ones the DUT just sampled.
    initial begin : monitor
        logic [NUM_CH-1:0] prev_trig;
        logic              prev_busy;
        exp_t              e;
        prev_trig = '0;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cur_valid   = 1'b0;
                phase       = 0;
                pulse_ticks = 0;
                hold_ticks  = 0;
                prev_trig   = '0;
                prev_busy   = 1'b0;
            end else begin
                chk("trig_onehot", int'($countones(o_trig) <= 1), 1);
                if (prev_trig != 0 && i_tick) pulse_ticks++;
                if (prev_busy && prev_trig == 0 && i_tick) hold_ticks++;
                if (prev_trig != 0 && o_trig == 0) begin
                    chk("pulse_ticks", pulse_ticks, PULSE);
                    phase      = 2;
                    hold_ticks = 0;
                end
                if (o_done) begin
                    done_count++;
                    if (!cur_valid || phase != 2) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        chk("hold_ticks", hold_ticks, cur.hold);
                    end
                    cur_valid = 1'b0;
                    phase     = 0;
                end
                if (prev_trig == 0 && o_trig != 0) begin
                    rise_count++;
                    phase       = 1;
                    pulse_ticks = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_trig", int'(o_trig), 0);
                        cur_valid = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("trig_channel", int'(o_trig), 1 << e.ch);
                        chk("ch_sel", int'(o_ch_sel), e.ch);
                        chk("chained_done", int'(o_done), int'(e.chained));
                        cur       = e;
                        cur_valid = 1'b1;
                    end
                end
                chk("busy_vs_phase", int'(o_busy), int'(phase != 0));
                prev_trig = o_trig;
                prev_busy = o_busy;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Issue one single-shot request, queueing the predicted trigger.
    task automatic fire_start(int hold);
        int c;
        c = next_ch(model_last, i_ch_mask);
        if (c >= 0) begin
            exp_q.push_back('{ch: c, chained: 1'b0, hold: hold});
            model_last = c;
        end
        pulse_start();
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((o_busy || exp_q.size() != 0 || cur_valid) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, int'(n >= BUDGET), 0);
    endtask

    // Wait until the monitor reports phase 'ph' with at least 't' ticks.
    task automatic wait_phase(int ph, int t, string name);
        int n = 0;
        while (!(phase == ph && ((ph == 1) ? pulse_ticks : hold_ticks) >= t) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_phase_timeout"}, int'(n >= BUDGET), 0);
    endtask

    task automatic run_auto(int k, string name);
        int base;
        int n;
        int c;
        base = rise_count;
        if (i_ch_mask == 0) begin
            @(negedge clk);
            i_auto = 1'b1;
            repeat (4) @(negedge clk);
            i_auto = 1'b0;
            chk({name, "_auto_nomask_rises"}, rise_count - base, 0);
            return;
        end
        for (int i = 0; i < k; i++) begin
            c = next_ch(model_last, i_ch_mask);
            exp_q.push_back('{ch: c, chained: (i > 0), hold: HOLD});
            model_last = c;
        end
        @(negedge clk);
        i_auto = 1'b1;
        n = 0;
        while (rise_count < base + k && n < BUDGET * k) begin
            @(negedge clk);
            n++;
        end
        i_auto = 1'b0;
        chk({name, "_auto_timeout"}, int'(n >= BUDGET * k), 0);
        wait_idle(name);
    endtask

    task automatic check_idle_outputs(string name);
        chk({name, "_busy"}, int'(o_busy), 0);
        chk({name, "_trig"}, int'(o_trig), 0);
        chk({name, "_ch_sel"}, int'(o_ch_sel), model_last);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: time limit reached, got busy=%0b, expected test completion", o_busy);
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        int mode;
        bit busy_seen;
        bit trig_seen;

        rst         = 1'b1;
        i_start     = 1'b0;
        i_auto      = 1'b0;
        i_ch_mask   = '0;
        i_echo_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_trig", int'(o_trig), 0);
        chk("reset_ch_sel", int'(o_ch_sel), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);

        // Single shot on the lowest channel.
        i_ch_mask = 4'b1111;
        base = done_count;
        fire_start(HOLD);
        wait_idle("t1");
        chk("t1_done_count", done_count - base, 1);
        check_idle_outputs("t1");

        // Round-robin 1,2,3 then wrap to 0.
        for (int i = 0; i < 4; i++) begin
            fire_start(HOLD);
            wait_idle("t2");
            check_idle_outputs("t2");
        end

        // Continuous mode over a sparse mask: 1,3,1,3,1.
        i_ch_mask = 4'b1010;
        run_auto(5, "t3");
        check_idle_outputs("t3");

        // Empty mask: no activity for either request kind.
        i_ch_mask = '0;
        base = rise_count;
        busy_seen = 1'b0;
        trig_seen = 1'b0;
        pulse_start();
        @(negedge clk);
        i_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) i_auto = 1'b0;
            busy_seen |= o_busy;
            trig_seen |= (o_trig != 0);
        end
        chk("t4_busy_seen", int'(busy_seen), 0);
        chk("t4_trig_seen", int'(trig_seen), 0);
        chk("t4_rises", rise_count - base, 0);

        // Start during holdoff is dropped, not queued.
        i_ch_mask = 4'b1111;
        base = rise_count;
        fire_start(HOLD);
        wait_phase(2, 2, "t4b");
        pulse_start();
        wait_idle("t4b");
        repeat (10) @(negedge clk);
        chk("t4b_rises", rise_count - base, 1);

        // Asynchronous reset mid-pulse.
        i_ch_mask = 4'b0110;
        fire_start(HOLD);
        wait_phase(1, 5, "t5");
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_trig", int'(o_trig), 0);
        chk("t5_rst_busy", int'(o_busy), 0);
        chk("t5_rst_done", int'(o_done), 0);
        chk("t5_rst_ch_sel", int'(o_ch_sel), 0);
        exp_q.delete();
        model_last = NUM_CH - 1;
        base = done_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t5_no_done", done_count - base, 0);
        fire_start(HOLD);
        wait_idle("t5");
        check_idle_outputs("t5");

`ifdef SR04_ECHO_EARLY_EN
        // Echo finishing after three holdoff ticks ends the window.
        i_ch_mask = 4'b1111;
        fire_start(3);
        wait_phase(2, 3, "t6");
        i_echo_done = 1'b1;
        @(negedge clk);
        i_echo_done = 1'b0;
        wait_idle("t6");
        // Echo strobe during the pulse is ignored.
        fire_start(HOLD);
        wait_phase(1, 2, "t6b");
        i_echo_done = 1'b1;
        @(negedge clk);
        i_echo_done = 1'b0;
        wait_idle("t6b");
`else
        i_ch_mask = 4'b1111;
        fire_start(HOLD);
        wait_idle("t6");
`endif
        check_idle_outputs("t6");

        // Randomised sequences; masks may change mid-pulse for single shots.
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            i_ch_mask = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                run_auto($urandom_range(1, 3), "rnd");
            end else begin
                base = rise_count;
                fire_start(HOLD);
                if (i_ch_mask != 0) begin
                    wait_phase(1, int'($urandom_range(0, 8)), "rnd");
                    @(negedge clk);
                    i_ch_mask = 4'($urandom_range(0, 15));
                    wait_idle("rnd");
                end else begin
                    repeat (6) @(negedge clk);
                    chk("rnd_nomask_rises", rise_count - base, 0);
                end
            end
            check_idle_outputs("rnd");
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
